// File: rtl/pcie_tcap_pkg.sv
// pcie_tcap_pkg
// Shared definitions for the tcap capture-frame encapsulation/decapsulation path.
//   pcie_tcaphdr         decoded 6-byte capture header (ver, dir, rsrv, 40-bit timestamp)
//   PCIE_TCAP_LEN        header length in bytes
//   PCIE_TCAP_BEAT_BYTES stream beat width in bytes
//   tcap_dec_state_t     decapsulator frame-parse state
//   tcap_parse()         wire-order header bytes -> pcie_tcaphdr
//   tcap_popcount()      number of valid bytes in a beat

package pcie_tcap_pkg;

    localparam int PCIE_TCAP_LEN        = 6;
    localparam int PCIE_TCAP_BEAT_BYTES = 8;

    // Field order matches the wire: byte0 holds ver/dir/rsrv, bytes 1..5 the
    // big-endian timestamp, so the packed struct is the header bytes read MSB-first.
    typedef struct packed {
        logic [2:0]  ver;
        logic [1:0]  dir;
        logic [2:0]  rsrv;
        logic [39:0] ts;
    } pcie_tcaphdr;

    typedef enum logic [1:0] {
        HDR,
        BODY,
        FLUSH,
        DROP
    } tcap_dec_state_t;

    // bytes_le carries header byte0 in [7:0]; swap to MSB-first and split fields.
    function automatic pcie_tcaphdr tcap_parse(bit [47:0] bytes_le);
        logic [47:0] bytes_be;
        for (int i = 0; i < PCIE_TCAP_LEN; i++) begin
            bytes_be[47 - 8*i -: 8] = bytes_le[8*i +: 8];
        end
        return pcie_tcaphdr'(bytes_be);
    endfunction

    function automatic logic [3:0] tcap_popcount(logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < PCIE_TCAP_BEAT_BYTES; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pcie_tcap_decap_realign.sv
// tcap_realign
// Holds the bytes of the previous beat that overhang the 6-byte header offset
// and builds the three possible output beats of the decapsulator.
//   clk, rst          clock, asynchronous active-high reset
//   in_data, in_keep  current input beat
//   res_load          capture input lanes 6..7 into the residual register
//   merge_data/keep   {input lanes 0..5, residual} (BODY beats)
//   head_data/keep    input lanes 6..7 moved to lanes 0..1 (7-8 byte frames)
//   flush_data/keep   residual alone in lanes 0..1 (FLUSH beat)

module tcap_realign
    import pcie_tcap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_keep,
    input  logic        res_load,
    output logic [63:0] merge_data,
    output logic [7:0]  merge_keep,
    output logic [63:0] head_data,
    output logic [7:0]  head_keep,
    output logic [63:0] flush_data,
    output logic [7:0]  flush_keep
);

    localparam int RES_BYTES = PCIE_TCAP_BEAT_BYTES - PCIE_TCAP_LEN;

    logic [RES_BYTES*8-1:0] res_data_reg;
    logic [RES_BYTES-1:0]   res_keep_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_reg <= '0;
            res_keep_reg <= '0;
        end else if (res_load) begin
            res_data_reg <= in_data[63 -: RES_BYTES*8];
            res_keep_reg <= in_keep[7 -: RES_BYTES];
        end
    end

    // Residual bytes come first on the wire, so they occupy the low lanes and
    // the current beat's first six bytes shift up behind them.
    for (genvar gi = 0; gi < PCIE_TCAP_BEAT_BYTES; gi++) begin : g_lane
        if (gi < RES_BYTES) begin : g_low
            assign merge_data[gi*8 +: 8] = res_data_reg[gi*8 +: 8];
            assign merge_keep[gi]        = res_keep_reg[gi];
            assign head_data[gi*8 +: 8]  = in_data[(gi+PCIE_TCAP_LEN)*8 +: 8];
            assign head_keep[gi]         = in_keep[gi+PCIE_TCAP_LEN];
            assign flush_data[gi*8 +: 8] = res_data_reg[gi*8 +: 8];
            assign flush_keep[gi]        = res_keep_reg[gi];
        end else begin : g_high
            assign merge_data[gi*8 +: 8] = in_data[(gi-RES_BYTES)*8 +: 8];
            assign merge_keep[gi]        = in_keep[gi-RES_BYTES];
            assign head_data[gi*8 +: 8]  = 8'd0;
            assign head_keep[gi]         = 1'b0;
            assign flush_data[gi*8 +: 8] = 8'd0;
            assign flush_keep[gi]        = 1'b0;
        end
    end

endmodule

// File: rtl/pcie_tcap_decap.sv
// pcie_tcap_decap
// Strips the 6-byte tcap header from each incoming frame, checks its version,
// realigns the captured TLP to lane 0 and forwards it with the decoded header.
//   clk, rst                      clock, asynchronous active-high reset
//   s_tdata/tkeep/tlast/tvalid    tcap frame stream in, s_tready back-pressure
//   m_tdata/tkeep/tlast/tvalid    realigned TLP stream out, m_tready back-pressure
//   m_hdr                         decoded header, constant over a frame's beats
//   err_ver, err_runt             one-cycle drop-reason pulses
//   cnt_ok, cnt_drop              wrapping delivered / dropped frame counters

module pcie_tcap_decap
    import pcie_tcap_pkg::*;
#(
    parameter logic [2:0] EXP_VER = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_tdata,
    input  logic [7:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [47:0] m_hdr,
    output logic        err_ver,
    output logic        err_runt,
    output logic [31:0] cnt_ok,
    output logic [31:0] cnt_drop
);

    tcap_dec_state_t state_reg, state_next;

    pcie_tcaphdr in_hdr;
    logic [3:0]  in_bytes;
    logic        out_ready;

    logic [63:0] merge_data, head_data, flush_data;
    logic [7:0]  merge_keep, head_keep, flush_keep;

    logic        out_load;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic        hdr_load;
    logic        res_load;
    logic        ver_bad;
    logic        runt;
    logic        drop_inc;

    assign in_hdr    = tcap_parse(s_tdata[PCIE_TCAP_LEN*8-1:0]);
    assign in_bytes  = tcap_popcount(s_tkeep);
    // The single output register can take a new beat when empty or draining.
    assign out_ready = !m_tvalid || m_tready;

    tcap_realign u_realign (
        .clk        (clk),
        .rst        (rst),
        .in_data    (s_tdata),
        .in_keep    (s_tkeep),
        .res_load   (res_load),
        .merge_data (merge_data),
        .merge_keep (merge_keep),
        .head_data  (head_data),
        .head_keep  (head_keep),
        .flush_data (flush_data),
        .flush_keep (flush_keep)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HDR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_tready   = 1'b0;
        out_load   = 1'b0;
        out_data   = merge_data;
        out_keep   = merge_keep;
        out_last   = 1'b0;
        hdr_load   = 1'b0;
        res_load   = 1'b0;
        ver_bad    = 1'b0;
        runt       = 1'b0;
        drop_inc   = 1'b0;
        unique case (state_reg)
            HDR: begin
                s_tready = out_ready;
                if (s_tvalid && out_ready) begin
                    if (s_tlast && (in_bytes <= 4'(PCIE_TCAP_LEN))) begin
                        // Header alone or truncated: nothing to forward.
                        runt     = 1'b1;
                        drop_inc = 1'b1;
                    end else if (in_hdr.ver != EXP_VER) begin
                        ver_bad = 1'b1;
                        if (s_tlast) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_next = DROP;
                        end
                    end else begin
                        hdr_load = 1'b1;
                        res_load = 1'b1;
                        if (s_tlast) begin
                            // 7-8 byte frame: the 1-2 TLP bytes go out directly.
                            out_load = 1'b1;
                            out_data = head_data;
                            out_keep = head_keep;
                            out_last = 1'b1;
                        end else begin
                            state_next = BODY;
                        end
                    end
                end
            end
            BODY: begin
                s_tready = out_ready;
                if (s_tvalid && out_ready) begin
                    out_load = 1'b1;
                    res_load = 1'b1;
                    if (s_tlast) begin
                        if (in_bytes <= 4'(PCIE_TCAP_LEN)) begin
                            out_last   = 1'b1;
                            state_next = HDR;
                        end else begin
                            // Bytes 6..7 of the last beat still need their own beat.
                            state_next = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_ready) begin
                    out_load   = 1'b1;
                    out_data   = flush_data;
                    out_keep   = flush_keep;
                    out_last   = 1'b1;
                    state_next = HDR;
                end
            end
            DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    drop_inc   = 1'b1;
                    state_next = HDR;
                end
            end
            default: begin
                state_next = HDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_hdr    <= '0;
            err_ver  <= 1'b0;
            err_runt <= 1'b0;
            cnt_ok   <= '0;
            cnt_drop <= '0;
        end else begin
            err_ver  <= ver_bad;
            err_runt <= runt;
            if (out_load) begin
                m_tvalid <= 1'b1;
                m_tdata  <= out_data;
                m_tkeep  <= out_keep;
                m_tlast  <= out_last;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (hdr_load) begin
                m_hdr <= in_hdr;
            end
            if (m_tvalid && m_tready && m_tlast) begin
                cnt_ok <= cnt_ok + 32'd1;
            end
            if (drop_inc) begin
                cnt_drop <= cnt_drop + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tcap_decap.sv
// tb_pcie_tcap_decap
// Directed frame table, reset-in-flight sequence and randomized back-to-back
// frames under random back-pressure, all scored against a frame-level model:
// a valid frame's output is its TLP bytes cut into 8-byte chunks.

module tb_pcie_tcap_decap;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [47:0] m_hdr;
    logic        err_ver;
    logic        err_runt;
    logic [31:0] cnt_ok;
    logic [31:0] cnt_drop;

    always #5 clk = ~clk;

    pcie_tcap_decap #(.EXP_VER(3'b001)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_hdr    (m_hdr),
        .err_ver  (err_ver),
        .err_runt (err_runt),
        .cnt_ok   (cnt_ok),
        .cnt_drop (cnt_drop)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [47:0] hdr;
    } beat_t;

    typedef struct {
        int         len;
        logic [7:0] b0;
        int         beats;
        logic [7:0] lkeep;
        int         ok;
        int         drop;
        int         ver;
        int         runt;
    } vec_t;

    beat_t      exp_q[$];
    logic [7:0] frame_q[$];

    int checks = 0;
    int errors = 0;
    int exp_ok = 0, exp_drop = 0, exp_ver = 0, exp_runt = 0;
    int ver_seen = 0, runt_seen = 0, beat_cnt = 0;
    logic [7:0] last_keep = 8'd0;
    bit mon_en = 1'b1;
    int rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Frame-level reference: runt if the whole frame fits in the header,
    // dropped on a version mismatch, otherwise TLP bytes in 8-byte chunks.
    task automatic model_frame();
        int n;
        int tlp;
        logic [47:0] hdr;
        n = frame_q.size();
        if (n <= 6) begin
            exp_runt++;
            exp_drop++;
        end else if (frame_q[0][7:5] != 3'b001) begin
            exp_ver++;
            exp_drop++;
        end else begin
            hdr = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
            tlp = n - 6;
            for (int s = 0; s < tlp; s += 8) begin
                beat_t b;
                b.data = '0;
                b.keep = '0;
                for (int l = 0; l < 8; l++) begin
                    if (s + l < tlp) begin
                        b.data[l*8 +: 8] = frame_q[6 + s + l];
                        b.keep[l]        = 1'b1;
                    end
                end
                b.last = (s + 8 >= tlp);
                b.hdr  = hdr;
                exp_q.push_back(b);
            end
            exp_ok++;
        end
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: s_tready stayed 0 required 1 within 2000 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int b);
        int n;
        int nb;
        logic [63:0] d;
        logic [7:0]  k;
        n  = frame_q.size();
        nb = (n + 7) / 8;
        d  = {$urandom, $urandom};
        k  = '0;
        for (int l = 0; l < 8; l++) begin
            if (b*8 + l < n) begin
                d[l*8 +: 8] = frame_q[b*8 + l];
                k[l]        = 1'b1;
            end
        end
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = (b == nb - 1);
        s_tvalid = 1'b1;
        wait_accept();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame();
        int nb;
        nb = (frame_q.size() + 7) / 8;
        model_frame();
        for (int b = 0; b < nb; b++) begin
            drive_beat(b);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d expected beats still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Ready pattern: 0 = always ready, 1 = random 50%.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                m_tready = 1'($urandom_range(0, 1));
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        logic [63:0] mask;
        if (!rst) begin
            if (err_ver)  ver_seen++;
            if (err_runt) runt_seen++;
            if (m_tvalid) begin
                checks++;
                if (m_tkeep == 8'd0 || ((m_tkeep & (m_tkeep + 8'd1)) != 0)) begin
                    errors++;
                    $display("FAIL keep_shape: m_tkeep=%02h required nonzero and contiguous from lane 0", m_tkeep);
                end
            end
            if (m_tvalid && m_tready) begin
                beat_cnt++;
                last_keep = m_tkeep;
                if (mon_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: data=%016h keep=%02h last=%0b required no beat", m_tdata, m_tkeep, m_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        for (int l = 0; l < 8; l++) mask[l*8 +: 8] = {8{e.keep[l]}};
                        if ((m_tdata & mask) != e.data || m_tkeep != e.keep || m_tlast != e.last || m_hdr != e.hdr) begin
                            errors++;
                            $display("FAIL out_beat: data=%016h keep=%02h last=%0b hdr=%012h required data=%016h keep=%02h last=%0b hdr=%012h",
                                     m_tdata & mask, m_tkeep, m_tlast, m_hdr, e.data, e.keep, e.last, e.hdr);
                        end
                    end
                end
            end
        end
    end

    initial begin
        vec_t       vecs[13];
        logic [7:0] hb[6];
        int         bc0, vs0, rs0;
        logic [31:0] ok0, dr0;
        int         len;

        vecs[0]  = '{22, 8'h20, 2, 8'hFF, 1, 0, 0, 0};
        vecs[1]  = '{24, 8'h40, 0, 8'h00, 0, 1, 1, 0};
        vecs[2]  = '{22, 8'h20, 2, 8'hFF, 1, 0, 0, 0};
        vecs[3]  = '{13, 8'h20, 1, 8'h7F, 1, 0, 0, 0};
        vecs[4]  = '{16, 8'h20, 2, 8'h03, 1, 0, 0, 0};
        vecs[5]  = '{ 5, 8'h20, 0, 8'h00, 0, 1, 0, 1};
        vecs[6]  = '{ 7, 8'h20, 1, 8'h01, 1, 0, 0, 0};
        vecs[7]  = '{ 8, 8'h20, 1, 8'h03, 1, 0, 0, 0};
        vecs[8]  = '{14, 8'h20, 1, 8'hFF, 1, 0, 0, 0};
        vecs[9]  = '{15, 8'h20, 2, 8'h01, 1, 0, 0, 0};
        vecs[10] = '{ 6, 8'h40, 0, 8'h00, 0, 1, 0, 1};
        vecs[11] = '{ 9, 8'h40, 0, 8'h00, 0, 1, 1, 0};
        vecs[12] = '{ 7, 8'h60, 0, 8'h00, 0, 1, 1, 0};

        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata",  m_tdata, 64'd0);
        check("rst_m_hdr",    64'(m_hdr), 64'd0);
        check("rst_cnt_ok",   64'(cnt_ok), 64'd0);
        check("rst_cnt_drop", 64'(cnt_drop), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_tready), 64'd1);

        // Directed frames: header 0x20/0x40.. then ts bytes 00 00 00 12 34, TLP 0x00..
        for (int v = 0; v < 13; v++) begin
            hb[0] = vecs[v].b0;
            hb[1] = 8'h00; hb[2] = 8'h00; hb[3] = 8'h00; hb[4] = 8'h12; hb[5] = 8'h34;
            frame_q.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                if (i < 6) frame_q.push_back(hb[i]);
                else       frame_q.push_back(8'(i - 6));
            end
            bc0 = beat_cnt;
            vs0 = ver_seen;
            rs0 = runt_seen;
            ok0 = cnt_ok;
            dr0 = cnt_drop;
            $display("directed %0d: len=%0d byte0=%02h", v, vecs[v].len, vecs[v].b0);
            send_frame();
            drain();
            check("dir_beats",    64'(beat_cnt - bc0), 64'(vecs[v].beats));
            if (vecs[v].beats > 0) check("dir_last_keep", 64'(last_keep), 64'(vecs[v].lkeep));
            check("dir_cnt_ok",   64'(cnt_ok - ok0), 64'(vecs[v].ok));
            check("dir_cnt_drop", 64'(cnt_drop - dr0), 64'(vecs[v].drop));
            check("dir_err_ver",  64'(ver_seen - vs0), 64'(vecs[v].ver));
            check("dir_err_runt", 64'(runt_seen - rs0), 64'(vecs[v].runt));
            if (v == 0) check("dir_hdr", 64'(m_hdr), 64'h2000_0000_1234);
        end

        // Reset in the middle of a frame's body, then a fresh frame
        mon_en = 1'b0;
        frame_q.delete();
        frame_q.push_back(8'h20);
        for (int i = 1; i < 32; i++) frame_q.push_back(8'(8'hA0 + i));
        drive_beat(0);
        drive_beat(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_m_tdata",  m_tdata, 64'd0);
        check("midrst_m_tkeep",  64'(m_tkeep), 64'd0);
        check("midrst_m_tlast",  64'(m_tlast), 64'd0);
        check("midrst_m_hdr",    64'(m_hdr), 64'd0);
        check("midrst_cnt_ok",   64'(cnt_ok), 64'd0);
        check("midrst_cnt_drop", 64'(cnt_drop), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_ok = 0; exp_drop = 0; exp_ver = 0; exp_runt = 0;
        ver_seen = 0; runt_seen = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        frame_q.delete();
        frame_q.push_back(8'h24);
        for (int i = 1; i < 20; i++) frame_q.push_back(8'(8'h50 + i));
        $display("post-reset frame: len=20 byte0=24");
        send_frame();
        drain();
        check("postrst_cnt_ok",   64'(cnt_ok), 64'd1);
        check("postrst_cnt_drop", 64'(cnt_drop), 64'd0);
        check("postrst_hdr",      64'(m_hdr), 64'h2451_5253_5455);

        // Random back-to-back frames with 50% output back-pressure
        rdy_mode = 1;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 40);
            frame_q.delete();
            if ($urandom_range(0, 4) == 0) frame_q.push_back(8'($urandom));
            else                           frame_q.push_back({3'b001, 5'($urandom)});
            for (int i = 1; i < len; i++) frame_q.push_back(8'($urandom));
            $display("random %0d: len=%0d byte0=%02h", f, len, frame_q[0]);
            send_frame();
        end
        drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("final_cnt_ok",   64'(cnt_ok), 64'(exp_ok));
        check("final_cnt_drop", 64'(cnt_drop), 64'(exp_drop));
        check("final_err_ver",  64'(ver_seen), 64'(exp_ver));
        check("final_err_runt", 64'(runt_seen), 64'(exp_runt));
        check("final_pending",  64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_tcap_decap.md
# pcie_tcap_decap

Receive-side counterpart of the tcap header encapsulation: consumes a 64-bit AXI-Stream of tcap frames, each a 6-byte `pcie_tcaphdr` followed by the captured TLP bytes. Strips and decodes the header, checks the version, realigns the TLP payload to byte lane 0, and forwards it with the decoded header as frame-constant sideband. Sits between the capture replay/host DMA stream and the TLP analysis pipeline.

## Interface
- `EXP_VER`, default 3'b001: accepted `ver` value; any other value drops the frame.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_tdata`  in  64  input bytes; lane 0 (`[7:0]`) is the first byte on the wire.
- `s_tkeep`  in  8  byte enables; contiguous from lane 0, all ones except on the `tlast` beat (input constraint).
- `s_tlast`  in  1  last beat of frame.
- `s_tvalid`  in  1, `s_tready`  out  1  input handshake.
- `m_tdata`  out  64, `m_tkeep`  out  8, `m_tlast`  out  1  realigned TLP stream, same lane rules as input.
- `m_tvalid`  out  1, `m_tready`  in  1  output handshake.
- `m_hdr`  out  48  decoded `pcie_tcaphdr`, stable for every beat of the frame.
- `err_ver`  out  1  one-cycle pulse when a frame is dropped for version mismatch.
- `err_runt`  out  1  one-cycle pulse when a frame ends with ≤6 bytes.
- `cnt_ok`  out  32, `cnt_drop`  out  32  wrapping frame counters.

## Operation
- Header decode, first beat: byte0 `[7:5]`=ver, `[4:3]`=dir, `[2:0]`=rsrv; ts = {byte1..byte5}, byte1 is MSB (ts[39:32]). Bytes 6–7 are the first two TLP bytes and go to the 2-byte residual register.
- States:
  - HDR: waits for the first beat.
    - `tlast` with popcount(tkeep) ≤ 6: pulse `err_runt`, increment `cnt_drop`, stay in HDR.
    - ver ≠ EXP_VER and no `tlast`: pulse `err_ver`, go to DROP.
    - ver ≠ EXP_VER with `tlast`: pulse `err_ver`, increment `cnt_drop`, stay in HDR.
    - Otherwise latch `m_hdr` and the residual, then go to BODY. If `tlast` (7–8 bytes), emit one beat with 1–2 bytes and `m_tlast`=1, and stay in HDR.
  - BODY: each accepted beat with n valid bytes emits {in bytes 0..5, residual} as one 8-byte beat; input bytes 6..7 become the new residual.
    - On `tlast` with n ≤ 6: emit 2+n bytes with `m_tlast`, go to HDR.
    - On `tlast` with n = 7 or 8: emit 8 bytes without `m_tlast`, go to FLUSH.
  - FLUSH: emit the residual (n−6 bytes) with `m_tlast`, then go to HDR.
  - DROP: `s_tready`=1 and no output. On `tlast`, increment `cnt_drop` and go to HDR.
- `cnt_ok` increments when an output beat with `m_tlast` is accepted.
- `m_tkeep` is always contiguous from lane 0. `m_tkeep`=0 never occurs with `m_tvalid`=1.

## Timing
- Single registered output stage; `s_tready` = (!`m_tvalid` || `m_tready`) in HDR/BODY, 0 in FLUSH, 1 in DROP.
- Latency: first output beat is valid the cycle after the second input beat is accepted, or after the header beat for a 7–8-byte frame. Steady state is one beat per cycle with no bubbles. A frame whose last beat has 7–8 bytes costs one extra cycle (FLUSH).
- `m_tdata`/`m_tkeep`/`m_tlast`/`m_hdr` hold while `m_tvalid` && !`m_tready`.
- A new frame's header is accepted the cycle after the previous `tlast` is consumed. `m_hdr` updates only when the HDR beat is accepted.
- Reset (async, any state): state=HDR; `m_tvalid`=0, `m_tdata`=0, `m_tkeep`=0, `m_tlast`=0, `m_hdr`=0, residual cleared, `err_*`=0, counters=0, `s_tready`=1 after release. A partial frame in flight is discarded.

## Structure
- Add to `pcie_tcap_pkg`:
  - `PCIE_TCAP_BEAT_BYTES` = 8.
  - a `tcap_parse(bit [47:0] bytes_le)` function returning `pcie_tcaphdr` (byte swap plus field split).
  - a state enum `tcap_dec_state_t` {HDR, BODY, FLUSH, DROP}.
- Reuse `PCIE_TCAP_LEN` for the 6-byte offset.
- One sub-module, `tcap_realign`: residual register plus 6-byte shift/merge and tkeep computation. The FSM and counters stay in the top.

## Test plan
- Header bytes 0x20,0x00,0x00,0x00,0x12,0x34 followed by a 16-byte TLP 0x00..0x0F (3 beats) → 2 out beats, data 0x00..0x0F in order, last `m_tkeep`=0xFF; `m_hdr.ts`=0x1234, dir=0, ver=1; `cnt_ok`=1.
- Byte0 = 0x40 (ver=2), 24-byte frame → no `m_tvalid`, `err_ver` pulses once, `cnt_drop`=1; the next valid frame passes.
- 13-byte frame (last beat 5 bytes) → one out beat `m_tkeep`=0x7F with `m_tlast`. 16-byte frame → 8-byte beat, then FLUSH beat `m_tkeep`=0x03 with `m_tlast`.
- 5-byte frame → `err_runt`, no output. 7-byte frame → single beat `m_tkeep`=0x01, `m_tlast`=1.
- Random `m_tready` (50%) over 100 back-to-back random frames → output matches the scoreboard byte-exact, no beat lost or duplicated, and `m_hdr` stays constant within each frame.
- Assert `rst` mid-BODY, then resume with a fresh frame → outputs zero during reset; the fresh frame is decoded correctly and no stale residual bytes appear.
